// File: rtl/pc_sequencer.sv
`default_nettype none
// pc_sequencer: priority next-PC selection with fetch capture; define PC_SEQ_RAS_EN
// to compile in the circular return-address stack. Rev 1.0
module pc_sequencer #(
  parameter int ADDR_W = 28,
  parameter int STEP = 1,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter int RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch,
  input  logic              incpc,
  input  logic              stall,
  input  logic              branch_en,
  input  logic [ADDR_W-1:0] branch_off,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic              call_en,
  input  logic              ret_en,
  output logic [ADDR_W-1:0] pcout,
  output logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_valid,
  output logic              ras_empty,
  output logic              ras_full,
  output logic              ras_err
);

  localparam logic [ADDR_W-1:0] STEP_V = ADDR_W'(STEP);

  logic [ADDR_W-1:0] pc_next;

`ifdef PC_SEQ_RAS_EN
  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam logic [PTR_W:0] DEPTH_V = (PTR_W+1)'(RAS_DEPTH);

  logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  top_ptr;
  logic [PTR_W:0]    count;
  logic [PTR_W:0]    count_next;
  logic              push;
  logic              pop;
  logic              err_set;

  assign top_ptr = wr_ptr - PTR_W'(1);
`else
  logic unused_ras;
  assign unused_ras = ret_en & (RAS_DEPTH > 0);
  assign ras_empty  = 1'b1;
  assign ras_full   = 1'b0;
  assign ras_err    = 1'b0;
`endif

  always_comb begin
    pc_next = pcout;
`ifdef PC_SEQ_RAS_EN
    push    = 1'b0;
    pop     = 1'b0;
    err_set = 1'b0;
`endif
    if (!stall) begin
      if (call_en) begin
        pc_next = jump_addr;
`ifdef PC_SEQ_RAS_EN
        push = 1'b1;
`endif
      end else if (jump_en) begin
        pc_next = jump_addr;
`ifdef PC_SEQ_RAS_EN
      end else if (ret_en) begin
        // An empty-stack return holds the PC and only raises the error flag.
        if (count != '0) begin
          pc_next = ras_mem[top_ptr];
          pop     = 1'b1;
        end else begin
          err_set = 1'b1;
        end
`endif
      end else if (branch_en) begin
        pc_next = pcout + branch_off;
      end else if (incpc) begin
        pc_next = pcout + STEP_V;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcout       <= RESET_VEC;
      fetch_addr  <= '0;
      fetch_valid <= 1'b0;
    end else begin
      pcout       <= pc_next;
      fetch_valid <= fetch;
      if (fetch) fetch_addr <= pcout;
    end
  end

`ifdef PC_SEQ_RAS_EN
  // A push into a full stack overwrites the oldest slot, so the count saturates.
  always_comb begin
    count_next = count;
    if (push && count != DEPTH_V) count_next = count + (PTR_W+1)'(1);
    else if (pop)                 count_next = count - (PTR_W+1)'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      count     <= '0;
      ras_empty <= 1'b1;
      ras_full  <= 1'b0;
      ras_err   <= 1'b0;
    end else begin
      if (push)     wr_ptr <= wr_ptr + PTR_W'(1);
      else if (pop) wr_ptr <= top_ptr;
      count     <= count_next;
      ras_empty <= (count_next == '0);
      ras_full  <= (count_next == DEPTH_V);
      if (err_set || (push && count == DEPTH_V)) ras_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) ras_mem[wr_ptr] <= pcout + STEP_V;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// tb_pc_sequencer: randomized scoreboard bench against a queue-based PC/stack model. Rev 1.0
module tb_pc_sequencer;
  localparam int ADDR_W = 28;
  localparam int STEP = 1;
  localparam int RAS_DEPTH = 4;
  localparam logic [ADDR_W-1:0] RESET_VEC = '0;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef struct packed {
    addr_t pc;
    addr_t fa;
    logic  fv;
    logic  emp;
    logic  full;
    logic  err;
  } exp_t;

  logic  clk = 1'b0;
  logic  reset = 1'b1;
  logic  fetch = 0, incpc = 0, stall = 0, branch_en = 0, jump_en = 0, call_en = 0, ret_en = 0;
  addr_t branch_off = '0, jump_addr = '0;
  addr_t pcout, fetch_addr;
  logic  fetch_valid, ras_empty, ras_full, ras_err;

  pc_sequencer #(.ADDR_W(ADDR_W), .STEP(STEP), .RESET_VEC(RESET_VEC), .RAS_DEPTH(RAS_DEPTH)) dut (
    .clk(clk), .reset(reset), .fetch(fetch), .incpc(incpc), .stall(stall),
    .branch_en(branch_en), .branch_off(branch_off), .jump_en(jump_en), .jump_addr(jump_addr),
    .call_en(call_en), .ret_en(ret_en), .pcout(pcout), .fetch_addr(fetch_addr),
    .fetch_valid(fetch_valid), .ras_empty(ras_empty), .ras_full(ras_full), .ras_err(ras_err)
  );

  always #5 clk = ~clk;

  exp_t  exp_q[$];
  addr_t fetch_q[$];
  int    checks = 0;
  int    errors = 0;

  addr_t m_pc, m_fa;
  logic  m_fv, m_err;
  addr_t m_stack[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t snapshot();
    exp_t e;
    e.pc = m_pc; e.fa = m_fa; e.fv = m_fv;
`ifdef PC_SEQ_RAS_EN
    e.emp = (m_stack.size() == 0); e.full = (m_stack.size() == RAS_DEPTH); e.err = m_err;
`else
    e.emp = 1'b1; e.full = 1'b0; e.err = 1'b0;
`endif
    return e;
  endfunction

  task automatic model_reset();
    m_pc = RESET_VEC; m_fa = '0; m_fv = 1'b0; m_err = 1'b0;
    m_stack.delete();
    fetch_q.delete();
  endtask

  // Reference behaviour: a queue is the stack, oldest entry at the front.
  task automatic model_step(input logic f, ip, st, be, input addr_t bo,
                            input logic je, input addr_t ja, input logic ce, re);
    addr_t old = m_pc;
    if (f) begin m_fa = old; fetch_q.push_back(old); end
    m_fv = f;
    if (!st) begin
      if (ce) begin
`ifdef PC_SEQ_RAS_EN
        m_stack.push_back(addr_t'(old + STEP));
        if (m_stack.size() > RAS_DEPTH) begin void'(m_stack.pop_front()); m_err = 1'b1; end
`endif
        m_pc = ja;
      end else if (je) m_pc = ja;
`ifdef PC_SEQ_RAS_EN
      else if (re) begin
        if (m_stack.size() > 0) m_pc = m_stack.pop_back();
        else m_err = 1'b1;
      end
`endif
      else if (be) m_pc = addr_t'(old + bo);
      else if (ip) m_pc = addr_t'(old + STEP);
    end
  endtask

  task automatic cycle(input logic f, ip, st, be, input addr_t bo,
                       input logic je, input addr_t ja, input logic ce, re);
    @(negedge clk);
    reset = 1'b0;
    fetch = f; incpc = ip; stall = st; branch_en = be; branch_off = bo;
    jump_en = je; jump_addr = ja; call_en = ce; ret_en = re;
    model_step(f, ip, st, be, bo, je, ja, ce, re);
    exp_q.push_back(snapshot());
  endtask

  task automatic idle(); cycle(0, 0, 0, 0, '0, 0, '0, 0, 0); endtask

  // Reset raised between edges must act before the next rising edge.
  task automatic async_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    fetch = 0; incpc = 0; stall = 0; branch_en = 0; jump_en = 0; call_en = 0; ret_en = 0;
    #1;
    chk("async_pcout", 32'(pcout), 32'(RESET_VEC));
    chk("async_fetch_valid", 32'(fetch_valid), 32'd0);
    chk("async_fetch_addr", 32'(fetch_addr), 32'd0);
    chk("async_ras_empty", 32'(ras_empty), 32'd1);
    chk("async_ras_err", 32'(ras_err), 32'd0);
    model_reset();
    exp_q.push_back(snapshot());
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (fetch_valid) begin
        if (fetch_q.size() == 0) chk("fetch_unexpected", 32'(fetch_valid), 32'd0);
        else chk("fetch_addr_pop", 32'(fetch_addr), 32'(fetch_q.pop_front()));
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pcout", 32'(pcout), 32'(e.pc));
        chk("fetch_addr", 32'(fetch_addr), 32'(e.fa));
        chk("fetch_valid", 32'(fetch_valid), 32'(e.fv));
        chk("ras_empty", 32'(ras_empty), 32'(e.emp));
        chk("ras_full", 32'(ras_full), 32'(e.full));
        chk("ras_err", 32'(ras_err), 32'(e.err));
      end
    end
  end

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic f, ip, st, be, je, ce, re;
    addr_t bo, ja;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_pcout", 32'(pcout), 32'(RESET_VEC));
    chk("reset_fetch_valid", 32'(fetch_valid), 32'd0);
    chk("reset_ras_empty", 32'(ras_empty), 32'd1);
    chk("reset_ras_full", 32'(ras_full), 32'd0);

    repeat (3) cycle(1, 1, 0, 0, '0, 0, '0, 0, 0);
    idle();
    cycle(0, 0, 0, 0, '0, 1, 28'h0000010, 0, 0);
    cycle(0, 1, 0, 1, 28'hFFFFFF8, 0, '0, 0, 0);
    cycle(0, 0, 0, 0, '0, 1, 28'hFFFFFFF, 0, 0);
    cycle(0, 1, 0, 0, '0, 0, '0, 0, 0);
    cycle(1, 0, 1, 0, '0, 1, 28'h0000123, 0, 0);
    cycle(0, 0, 0, 0, '0, 1, 28'h0000100, 0, 0);
    cycle(0, 0, 0, 0, '0, 0, 28'h0000400, 1, 0);
    cycle(0, 0, 0, 0, '0, 0, '0, 0, 1);
    idle();

    async_reset();
    for (int i = 0; i < 5; i++) cycle(1, 0, 0, 0, '0, 0, addr_t'(28'h1000 * (i + 1)), 1, 0);
    for (int i = 0; i < 5; i++) cycle(1, 1, 0, 1, 28'h4, 0, '0, 0, 1);
    cycle(0, 0, 0, 0, '0, 0, 28'h0000777, 1, 0);
    async_reset();
    cycle(1, 1, 0, 0, '0, 0, '0, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        async_reset();
      end else begin
        f  = $urandom_range(0, 1) == 1;
        ip = $urandom_range(0, 1) == 1;
        st = $urandom_range(0, 7) == 0;
        be = $urandom_range(0, 5) == 0;
        je = $urandom_range(0, 7) == 0;
        ce = $urandom_range(0, 5) == 0;
        re = $urandom_range(0, 4) == 0;
        bo = ($urandom_range(0, 1) == 1) ? addr_t'($urandom) : addr_t'($urandom_range(0, 31) - 16);
        ja = ($urandom_range(0, 3) == 0) ? addr_t'(28'hFFFFFF0 + $urandom_range(0, 15))
                                         : addr_t'($urandom);
        cycle(f, ip, st, be, bo, je, ja, ce, re);
      end
    end

    idle();
    repeat (3) @(posedge clk);
    #2;
    chk("exp_queue_drained", 32'(exp_q.size()), 32'd0);
    chk("fetch_queue_drained", 32'(fetch_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
